// File: rtl/division_pkg.sv
// Shared definitions for the restoring divider and its reconstructor.
//   DIV_WIDTH  : default operand width used by both blocks
//   IDLE/RUN/DONE : FSM state encodings (2-bit, legacy-compatible constants)
//   cnt_width() : width of an iteration counter that counts 0..w-1
package division_pkg;

  localparam int DIV_WIDTH = 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // $clog2(1) is 0, which would give a zero-width counter.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/division_reconstructor_if.sv
// Request/result bus of the division reconstructor.
//   start, quotient, divisor, remainder : request, driven by the master
//   busy, done, dividend_out, overflow  : status/result, driven by the slave
interface division_reconstructor_if
  import division_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) ();

  logic               start;
  logic [WIDTH-1:0]   quotient;
  logic [WIDTH-1:0]   divisor;
  logic [WIDTH-1:0]   remainder;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] dividend_out;
  logic               overflow;

  modport master (
    output start, quotient, divisor, remainder,
    input  busy, done, dividend_out, overflow
  );

  modport slave (
    input  start, quotient, divisor, remainder,
    output busy, done, dividend_out, overflow
  );

endinterface

// File: rtl/division_reconstructor.sv
// Rebuilds a dividend from a divider result: dividend_out = quotient*divisor
// + remainder (unsigned), one shift-and-add iteration per clock.
//   clock   : rising-edge clock
//   reset_n : synchronous active-low reset
//   bus     : slave side of division_reconstructor_if
//             start/quotient/divisor/remainder in,
//             busy/done/dividend_out/overflow out
// Latency is fixed at WIDTH iterations regardless of operand values; done
// pulses for one cycle and the result holds until the next completion.
module division_reconstructor
  import division_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic                     clock,
  input  logic                     reset_n,
  division_reconstructor_if.slave  bus
);

  localparam int CW = cnt_width(WIDTH);

  logic [1:0]         state;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      count;
  logic               busy_q;
  logic               done_q;
  logic [2*WIDTH-1:0] result_q;
  logic               ovf_q;

  logic               accept;
  logic               last;
  logic [2*WIDTH-1:0] acc_sum;

  // Operands are only taken when not iterating; DONE accepts too so that
  // back-to-back operations cost no idle cycle.
  assign accept  = bus.start && ((state == IDLE) || (state == DONE));
  assign last    = (count == CW'(WIDTH - 1));
  // acc starts at remainder and partial products are added onto it, so the
  // final acc is already quotient*divisor + remainder. Max value
  // (2^W-1)^2 + 2^W-1 < 2^(2W), so the add never carries out.
  assign acc_sum = mplier[0] ? (acc + mcand) : acc;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= IDLE;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      count    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            acc    <= {{WIDTH{1'b0}}, bus.remainder};
            mcand  <= {{WIDTH{1'b0}}, bus.divisor};
            mplier <= bus.quotient;
            count  <= '0;
            busy_q <= 1'b1;
            done_q <= 1'b0;
            state  <= RUN;
          end else begin
            done_q <= 1'b0;
            state  <= IDLE;
          end
        end
        RUN: begin
          acc    <= acc_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + CW'(1);
          if (last) begin
            result_q <= acc_sum;
            ovf_q    <= |acc_sum[2*WIDTH-1:WIDTH];
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state    <= DONE;
          end
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.dividend_out = result_q;
  assign bus.overflow     = ovf_q;

endmodule

// File: tb/tb_division_reconstructor.sv
module tb_division_reconstructor;

  localparam int W = 8;

  logic clock;
  logic reset_n;
  int   errors;
  int   checks;

  division_reconstructor_if #(.WIDTH(W)) bus ();

  division_reconstructor #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drives one operation with a start pulse, scrambles the inputs during RUN,
  // and checks busy/done timing and the final result.
  task automatic run_op(input string name, input logic [W-1:0] q,
                        input logic [W-1:0] d, input logic [W-1:0] r,
                        input logic [2*W-1:0] exp, input logic exp_ovf);
    @(negedge clock);
    bus.start = 1'b1; bus.quotient = q; bus.divisor = d; bus.remainder = r;
    @(posedge clock);
    @(negedge clock);
    bus.start = 1'b0; bus.quotient = ~q; bus.divisor = ~d; bus.remainder = ~r;
    checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL %s accept: busy=%b done=%b expected busy=1 done=0", name, bus.busy, bus.done);
    end
    for (int i = 1; i <= W; i++) begin
      @(posedge clock);
      @(negedge clock);
      if (i == W - 4) begin
        // stray start mid-run must be ignored
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      if (i < W) begin
        checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
          errors++;
          $display("FAIL %s run cycle %0d: busy=%b done=%b expected busy=1 done=0", name, i, bus.busy, bus.done);
        end
      end
    end
    bus.start = 1'b0;
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s done: busy=%b done=%b expected busy=0 done=1", name, bus.busy, bus.done);
    end
    checks++;
    if (bus.dividend_out !== exp || bus.overflow !== exp_ovf) begin
      errors++;
      $display("FAIL %s result: dividend_out=%0d overflow=%b expected %0d/%b", name, bus.dividend_out, bus.overflow, exp, exp_ovf);
    end
    @(posedge clock);
    @(negedge clock);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.dividend_out !== exp) begin
      errors++;
      $display("FAIL %s after done: done=%b busy=%b dividend_out=%0d expected 0/0/%0d", name, bus.done, bus.busy, bus.dividend_out, exp);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.start = 1'b0; bus.quotient = 8'd1; bus.divisor = 8'd1; bus.remainder = 8'd1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.dividend_out !== 16'd0 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b out=%0d ovf=%b expected all 0", bus.busy, bus.done, bus.dividend_out, bus.overflow);
    end
    // start while in reset must not launch anything
    bus.start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_start: busy=%b expected 0", bus.busy);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    run_op("basic_13x5+2", 8'd13, 8'd5, 8'd2, 16'd67, 1'b0);
  endtask

  task automatic test_boundaries();
    run_op("all_ones_rem254", 8'd255, 8'd255, 8'd254, 16'hFEFF, 1'b1);
    run_op("all_ones", 8'd255, 8'd255, 8'd255, 16'hFF00, 1'b1);
    run_op("divisor_zero", 8'd200, 8'd0, 8'd7, 16'd7, 1'b0);
    run_op("quotient_zero", 8'd0, 8'd99, 8'd9, 16'd9, 1'b0);
    run_op("just_fits", 8'd1, 8'd255, 8'd0, 16'd255, 1'b0);
    run_op("just_over", 8'd1, 8'd255, 8'd1, 16'd256, 1'b1);
  endtask

  // start held high throughout; a second operation is taken on the done edge.
  task automatic test_back_to_back();
    @(negedge clock);
    bus.start = 1'b1; bus.quotient = 8'd7; bus.divisor = 8'd9; bus.remainder = 8'd5;
    @(posedge clock);
    @(negedge clock);
    bus.quotient = 8'd255; bus.divisor = 8'd255; bus.remainder = 8'd255;
    for (int i = 1; i <= W; i++) begin
      @(posedge clock);
      @(negedge clock);
    end
    checks++;
    if (bus.done !== 1'b1 || bus.dividend_out !== 16'd68 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL b2b first: done=%b out=%0d ovf=%b expected 1/68/0", bus.done, bus.dividend_out, bus.overflow);
    end
    bus.quotient = 8'd3; bus.divisor = 8'd4; bus.remainder = 8'd1;
    @(posedge clock);
    @(negedge clock);
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.dividend_out !== 16'd68) begin
      errors++;
      $display("FAIL b2b reaccept: busy=%b done=%b out=%0d expected 1/0/68", bus.busy, bus.done, bus.dividend_out);
    end
    for (int i = 1; i <= W; i++) begin
      @(posedge clock);
      @(negedge clock);
      if (i == W - 1) begin
        checks++;
        if (bus.dividend_out !== 16'd68 || bus.done !== 1'b0) begin
          errors++;
          $display("FAIL b2b hold: out=%0d done=%b expected 68/0", bus.dividend_out, bus.done);
        end
      end
    end
    checks++;
    if (bus.done !== 1'b1 || bus.dividend_out !== 16'd13) begin
      errors++;
      $display("FAIL b2b second: done=%b out=%0d expected 1/13", bus.done, bus.dividend_out);
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset_mid_run();
    @(negedge clock);
    bus.start = 1'b1; bus.quotient = 8'd200; bus.divisor = 8'd200; bus.remainder = 8'd0;
    @(posedge clock);
    @(negedge clock);
    bus.start = 1'b0;
    repeat (4) begin
      @(posedge clock);
      @(negedge clock);
    end
    reset_n = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.dividend_out !== 16'd0 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: busy=%b done=%b out=%0d ovf=%b expected all 0", bus.busy, bus.done, bus.dividend_out, bus.overflow);
    end
    repeat (W + 2) begin
      @(posedge clock);
      @(negedge clock);
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset_quiet: busy=%b done=%b expected 0/0", bus.busy, bus.done);
      end
    end
    run_op("after_reset", 8'd10, 8'd10, 8'd9, 16'd109, 1'b0);
  endtask

  task automatic test_loopback();
    int dv;
    int dd;
    for (int n = 0; n < 24; n++) begin
      dv = $urandom_range(0, 255);
      dd = $urandom_range(1, 255);
      run_op($sformatf("loopback_%0d/%0d", dv, dd), 8'(dv / dd), 8'(dd), 8'(dv % dd), 16'(dv), 1'b0);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_boundaries();
    test_back_to_back();
    test_reset_mid_run();
    test_loopback();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
